// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter and fetch control in front of the
// instruction ROM. Issues addresses, presents returned opcodes to the decoder
// over valid/ready, and executes CALL, RET and HALT locally using a small
// return-address stack.
module fetch_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int INSTR_BYTES = 4,
  parameter int STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] address,
  input  logic [31:0]       opcode,
  output logic [31:0]       instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              halted,
  output logic              stack_err
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [7:0] OP_CALL = 8'h30;
  localparam logic [7:0] OP_RET  = 8'h31;
  localparam logic [7:0] OP_HALT = 8'h32;

  typedef enum logic [1:0] {
    S_ISSUE   = 2'd0,
    S_PRESENT = 2'd1,
    S_HALT    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              stack_err_q, stack_err_d;

  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic              push_en;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  top_idx;
  logic [ADDR_W-1:0] pc_inc;
  logic              is_call;
  logic              is_ret;
  logic              is_halt;
  logic              is_internal;

  // Opcode classification uses the whole low byte so flagged variants fall through to the decoder
  always_comb begin
    is_call     = (opcode[7:0] == OP_CALL);
    is_ret      = (opcode[7:0] == OP_RET);
    is_halt     = (opcode[7:0] == OP_HALT);
    is_internal = is_call | is_ret | is_halt;
    pc_inc      = pc_q + ADDR_W'(INSTR_BYTES);
    push_idx    = IDX_W'(sp_q);
    top_idx     = IDX_W'(sp_q - SP_W'(1));
  end

  // Next-state logic: sequencing, stack push/pop and PC update on leaving PRESENT
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    address_d   = address_q;
    sp_d        = sp_q;
    stack_err_d = stack_err_q;
    push_en     = 1'b0;
    unique case (state_q)
      S_ISSUE: begin
        state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (is_call) begin
          if (sp_q < SP_W'(STACK_DEPTH)) begin
            push_en   = 1'b1;
            sp_d      = sp_q + SP_W'(1);
            pc_d      = ADDR_W'(opcode[23:16]);
            address_d = ADDR_W'(opcode[23:16]);
            state_d   = S_ISSUE;
          end else begin
            stack_err_d = 1'b1;
            state_d     = S_HALT;
          end
        end else if (is_ret) begin
          if (sp_q != '0) begin
            sp_d      = sp_q - SP_W'(1);
            pc_d      = stack_q[top_idx];
            address_d = stack_q[top_idx];
            state_d   = S_ISSUE;
          end else begin
            stack_err_d = 1'b1;
            state_d     = S_HALT;
          end
        end else if (is_halt) begin
          state_d = S_HALT;
        end else if (instr_ready) begin
          pc_d      = redirect_valid ? redirect_target : pc_inc;
          address_d = redirect_valid ? redirect_target : pc_inc;
          state_d   = S_ISSUE;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_ISSUE;
      pc_q        <= '0;
      address_q   <= '0;
      sp_q        <= '0;
      stack_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      address_q   <= address_d;
      sp_q        <= sp_d;
      stack_err_q <= stack_err_d;
    end
  end

  // Return-address storage; contents are meaningless until pushed, so no reset
  always_ff @(posedge clk) begin
    if (!rst && push_en) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  // Decoder-facing outputs: only non-internal opcodes in PRESENT are shown
  always_comb begin
    instr_valid = (state_q == S_PRESENT) && !is_internal;
    instr       = instr_valid ? opcode : 32'h0;
    halted      = (state_q == S_HALT);
    address     = address_q;
    stack_err   = stack_err_q;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed bench for fetch_sequencer with a registered
// ROM model; inputs are driven and outputs sampled on the falling edge.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  address;
  logic [31:0] opcode;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [7:0]  redirect_target;
  logic        halted;
  logic        stack_err;

  logic [31:0] rom [256];
  int          n_checks = 0;
  int          n_fail   = 0;

  fetch_sequencer #(
    .ADDR_W(8),
    .INSTR_BYTES(4),
    .STACK_DEPTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .address(address),
    .opcode(opcode),
    .instr(instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .halted(halted),
    .stack_err(stack_err)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // ROM returns the word one clock after the address is sampled
  always @(posedge clk) begin
    opcode <= rom[address];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic rv, input logic [7:0] tgt);
    instr_ready     = rdy;
    redirect_valid  = rv;
    redirect_target = tgt;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
  endtask

  task automatic fillRom();
    for (int i = 0; i < 256; i++) rom[i] = {8'hC0, 8'(i), 16'h5A01};
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00);
    fillRom();
    @(negedge clk);

    // Sequential flow: ADD, IMM-flagged opcode, HALT
    $display("[TB] sequential flow");
    rom[0] = 32'hA1B2C301;
    rom[4] = 32'h12345670;
    rom[8] = 32'h00000032;
    applyStimulus(1'b1, 1'b0, 8'h00);
    doReset();
    checkOutput("seq_c0_addr", 32'(address), 32'h00);
    checkOutput("seq_c0_valid", 32'(instr_valid), 32'd0);
    checkOutput("seq_c0_halted", 32'(halted), 32'd0);
    checkOutput("seq_c0_err", 32'(stack_err), 32'd0);
    checkOutput("seq_c0_instr", instr, 32'h0);
    stepCycle();
    checkOutput("seq_c1_valid", 32'(instr_valid), 32'd1);
    checkOutput("seq_c1_instr", instr, 32'hA1B2C301);
    stepCycle();
    checkOutput("seq_c2_addr", 32'(address), 32'h04);
    checkOutput("seq_c2_valid", 32'(instr_valid), 32'd0);
    stepCycle();
    checkOutput("seq_c3_valid", 32'(instr_valid), 32'd1);
    checkOutput("seq_c3_instr", instr, 32'h12345670);
    stepCycle();
    checkOutput("seq_c4_addr", 32'(address), 32'h08);
    stepCycle();
    checkOutput("seq_c5_valid", 32'(instr_valid), 32'd0);
    checkOutput("seq_c5_halted", 32'(halted), 32'd0);
    stepCycle();
    checkOutput("seq_c6_halted", 32'(halted), 32'd1);
    repeat (3) stepCycle();
    checkOutput("seq_c9_halted", 32'(halted), 32'd1);
    checkOutput("seq_c9_addr", 32'(address), 32'h08);
    checkOutput("seq_c9_valid", 32'(instr_valid), 32'd0);

    // Stall at PC 0x04 for five cycles, redirect ignored without accept
    $display("[TB] stall");
    fillRom();
    rom[8] = 32'h00000032;
    applyStimulus(1'b1, 1'b0, 8'h00);
    doReset();
    stepCycle();
    stepCycle();
    checkOutput("stall_issue_addr", 32'(address), 32'h04);
    applyStimulus(1'b0, 1'b1, 8'h40);
    stepCycle();
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("stall_valid_%0d", i), 32'(instr_valid), 32'd1);
      checkOutput($sformatf("stall_instr_%0d", i), instr, 32'hC0045A01);
      checkOutput($sformatf("stall_addr_%0d", i), 32'(address), 32'h04);
      if (i < 4) stepCycle();
    end
    applyStimulus(1'b1, 1'b0, 8'h00);
    stepCycle();
    checkOutput("stall_next_addr", 32'(address), 32'h08);
    checkOutput("stall_next_valid", 32'(instr_valid), 32'd0);

    // Redirect at PC 0x10 back to 0x04
    $display("[TB] redirect");
    fillRom();
    applyStimulus(1'b1, 1'b0, 8'h00);
    doReset();
    repeat (9) stepCycle();
    checkOutput("redir_pc10_addr", 32'(address), 32'h10);
    checkOutput("redir_pc10_instr", instr, 32'hC0105A01);
    applyStimulus(1'b1, 1'b1, 8'h04);
    stepCycle();
    checkOutput("redir_target_addr", 32'(address), 32'h04);
    applyStimulus(1'b1, 1'b0, 8'h00);
    stepCycle();
    checkOutput("redir_target_instr", instr, 32'hC0045A01);
    stepCycle();
    checkOutput("redir_after_addr", 32'(address), 32'h08);

    // CALL at 0x08 to 0x20, RET back to 0x0C
    $display("[TB] call and return");
    fillRom();
    rom[8'h08] = 32'h00200030;
    rom[8'h20] = 32'h00000031;
    rom[8'h0C] = 32'h00000032;
    applyStimulus(1'b1, 1'b0, 8'h00);
    doReset();
    repeat (4) stepCycle();
    checkOutput("call_addr", 32'(address), 32'h08);
    stepCycle();
    checkOutput("call_valid", 32'(instr_valid), 32'd0);
    stepCycle();
    checkOutput("call_target_addr", 32'(address), 32'h20);
    stepCycle();
    checkOutput("ret_valid", 32'(instr_valid), 32'd0);
    stepCycle();
    checkOutput("ret_addr", 32'(address), 32'h0C);
    repeat (2) stepCycle();
    checkOutput("callret_halted", 32'(halted), 32'd1);
    checkOutput("callret_err", 32'(stack_err), 32'd0);

    // Nine nested CALLs overflow an eight-entry stack
    $display("[TB] stack overflow");
    fillRom();
    for (int k = 0; k < 9; k++) rom[k * 16] = {8'h00, 8'(k * 16 + 16), 16'h0030};
    applyStimulus(1'b1, 1'b0, 8'h00);
    doReset();
    for (int k = 0; k < 9; k++) begin
      checkOutput($sformatf("ovf_addr_%0d", k), 32'(address), 32'(k * 16));
      stepCycle();
      checkOutput($sformatf("ovf_err_%0d", k), 32'(stack_err), 32'd0);
      stepCycle();
    end
    checkOutput("ovf_err_final", 32'(stack_err), 32'd1);
    checkOutput("ovf_halted_final", 32'(halted), 32'd1);

    // RET on an empty stack
    $display("[TB] stack underflow");
    fillRom();
    rom[0] = 32'h00000031;
    applyStimulus(1'b1, 1'b0, 8'h00);
    doReset();
    stepCycle();
    checkOutput("unf_valid", 32'(instr_valid), 32'd0);
    checkOutput("unf_err_early", 32'(stack_err), 32'd0);
    stepCycle();
    checkOutput("unf_err", 32'(stack_err), 32'd1);
    checkOutput("unf_halted", 32'(halted), 32'd1);
    stepCycle();
    checkOutput("unf_err_sticky", 32'(stack_err), 32'd1);

    // PC wraps from 0xFC to 0x00
    $display("[TB] wrap");
    fillRom();
    applyStimulus(1'b1, 1'b1, 8'hFC);
    doReset();
    stepCycle();
    stepCycle();
    checkOutput("wrap_fc_addr", 32'(address), 32'hFC);
    applyStimulus(1'b1, 1'b0, 8'h00);
    stepCycle();
    checkOutput("wrap_fc_instr", instr, 32'hC0FC5A01);
    stepCycle();
    checkOutput("wrap_next_addr", 32'(address), 32'h00);

    // Reset mid-stall after a CALL; the stack pointer must be cleared
    $display("[TB] reset during stall");
    fillRom();
    rom[0] = 32'h00400030;
    applyStimulus(1'b1, 1'b0, 8'h00);
    doReset();
    stepCycle();
    stepCycle();
    checkOutput("rst_call_addr", 32'(address), 32'h40);
    applyStimulus(1'b0, 1'b0, 8'h00);
    stepCycle();
    stepCycle();
    checkOutput("rst_stall_valid", 32'(instr_valid), 32'd1);
    rom[0] = 32'h00000031;
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("rst_valid_drop", 32'(instr_valid), 32'd0);
    checkOutput("rst_addr", 32'(address), 32'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    stepCycle();
    checkOutput("rst_ret_valid", 32'(instr_valid), 32'd0);
    stepCycle();
    checkOutput("rst_sp_cleared_err", 32'(stack_err), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
